// File: rtl/input_conditioner.sv
// input_conditioner
//   Cleans up the raw controller inputs before the game object units see them.
//   Each of the eight button/joystick lines is synchronised, debounced and turned
//   into a level plus one-cycle press/release pulses. Masked lines also produce
//   auto-repeat pulses while held. The 12-bit wheel reading is synchronised and
//   filtered with hysteresis so small jitter never moves the reported position.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   btn_raw[7:0]   {Down,Up,Left,Right,Start,Select,B,A}, async, 1 = pressed
//   wheel_raw[11:0] unsigned wheel reading, async
//   btn_level      debounced button state
//   btn_press      1-cycle pulse in the first cycle a level is 1
//   btn_release    1-cycle pulse in the first cycle a level is 0
//   btn_repeat     press pulse plus auto-repeat pulses on REPEAT_MASK bits
//   wheel_pos      filtered wheel position
//   wheel_changed  1-cycle pulse in the cycle wheel_pos takes a new value
module input_conditioner #(
  parameter int         DEBOUNCE_CYC     = 250000,
  parameter int         REPEAT_DELAY_CYC = 12500000,
  parameter int         REPEAT_RATE_CYC  = 2500000,
  parameter logic [7:0] REPEAT_MASK      = 8'hF0,
  parameter int         WHEEL_HYST       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  btn_raw,
  input  logic [11:0] wheel_raw,
  output logic [7:0]  btn_level,
  output logic [7:0]  btn_press,
  output logic [7:0]  btn_release,
  output logic [7:0]  btn_repeat,
  output logic [11:0] wheel_pos,
  output logic        wheel_changed
);

  localparam int NUM_LANES = 8;
  localparam int WHL_W     = 12;

  // ---------------- buttons ----------------
  logic [NUM_LANES-1:0] r_btn_s1, r_btn_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    input_conditioner_lane #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
      .REPEAT_EN        (REPEAT_MASK[g])
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_sync    (r_btn_s2[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

  // ---------------- wheel ----------------
  logic [WHL_W-1:0] r_whl_s1, r_whl_s2, r_whl_s3, r_wheel_pos;
  logic [2:0]       r_whl_vld;
  logic             r_init, r_wheel_chg;
  logic             w_stable, w_hyst_ok;
  logic [WHL_W:0]   w_diff;

  // The sync flops come out of reset holding zeros that were never sampled;
  // r_whl_vld tracks which stages hold a real sample so the first post-reset
  // position is the settled wheel reading rather than that cleared zero.
  assign w_stable  = r_whl_vld[2] && (r_whl_s2 == r_whl_s3);
  assign w_diff    = (r_whl_s2 >= r_wheel_pos) ? ({1'b0, r_whl_s2} - {1'b0, r_wheel_pos})
                                               : ({1'b0, r_wheel_pos} - {1'b0, r_whl_s2});
  assign w_hyst_ok = (w_diff >= (WHL_W+1)'(WHEEL_HYST));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_whl_s1    <= '0;
      r_whl_s2    <= '0;
      r_whl_s3    <= '0;
      r_whl_vld   <= '0;
      r_wheel_pos <= '0;
      r_wheel_chg <= 1'b0;
      r_init      <= 1'b1;
    end else begin
      r_whl_s1    <= wheel_raw;
      r_whl_s2    <= r_whl_s1;
      r_whl_s3    <= r_whl_s2;
      r_whl_vld   <= {r_whl_vld[1:0], 1'b1};
      r_wheel_chg <= 1'b0;
      if (w_stable && (r_init || w_hyst_ok)) begin
        r_wheel_pos <= r_whl_s2;
        r_wheel_chg <= 1'b1;
        r_init      <= 1'b0;
      end
    end
  end

  assign wheel_pos     = r_wheel_pos;
  assign wheel_changed = r_wheel_chg;

endmodule

// input_conditioner_lane
//   One button line: debounce counter, level/press/release registers and the
//   optional auto-repeat FSM.
// Ports
//   clk, reset   as top
//   i_sync       synchronised raw line
//   o_level      debounced level
//   o_press      1-cycle pulse on level rise
//   o_release    1-cycle pulse on level fall
//   o_repeat     press pulse plus repeat pulses (press pulse only if REPEAT_EN=0)
module input_conditioner_lane #(
  parameter int DEBOUNCE_CYC     = 250000,
  parameter int REPEAT_DELAY_CYC = 12500000,
  parameter int REPEAT_RATE_CYC  = 2500000,
  parameter bit REPEAT_EN        = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DBW  = $clog2(DEBOUNCE_CYC);
  localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DBW-1:0] DB_TC   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0]  DLY_TC  = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0]  RATE_TC = RW'(REPEAT_RATE_CYC - 1);

  // ---------------- debounce ----------------
  logic [DBW-1:0] r_cnt;
  logic           r_level, r_press, r_release;
  logic           w_mismatch, w_flip, w_rise, w_fall;

  assign w_mismatch = i_sync ^ r_level;
  assign w_flip     = w_mismatch && (r_cnt == DB_TC);
  assign w_rise     = w_flip & ~r_level;
  assign w_fall     = w_flip &  r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      if (!w_mismatch || w_flip) r_cnt <= '0;
      else                       r_cnt <= r_cnt + DBW'(1);
      if (w_flip) r_level <= ~r_level;
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // ---------------- auto-repeat ----------------
  // Driven from the same-cycle flip decision so repeat pulses line up with
  // btn_press and a release always suppresses a coincident repeat tick.
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

  rpt_state_t    r_state, w_state_nx;
  logic [RW-1:0] r_rcnt, w_rcnt_nx;
  logic          r_repeat, w_repeat_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rcnt   <= w_rcnt_nx;
      r_repeat <= w_repeat_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_rcnt_nx   = r_rcnt;
    w_repeat_nx = 1'b0;
    if (!REPEAT_EN) begin
      w_state_nx  = ST_IDLE;
      w_rcnt_nx   = '0;
      w_repeat_nx = w_rise;
    end else if (w_fall) begin
      w_state_nx = ST_IDLE;
      w_rcnt_nx  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nx  = ST_DELAY;
            w_rcnt_nx   = '0;
            w_repeat_nx = 1'b1;
          end
        end
        ST_DELAY: begin
          if (r_rcnt == DLY_TC) begin
            w_state_nx  = ST_REPEAT;
            w_rcnt_nx   = '0;
            w_repeat_nx = 1'b1;
          end else begin
            w_rcnt_nx = r_rcnt + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (r_rcnt == RATE_TC) begin
            w_rcnt_nx   = '0;
            w_repeat_nx = 1'b1;
          end else begin
            w_rcnt_nx = r_rcnt + RW'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_rcnt_nx  = '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with small timing parameters.
// Stimulus pushes every expected output event (any pulse on press/release/
// repeat/wheel_changed) with its absolute cycle; the monitor pops one entry
// per observed event and compares the whole output snapshot.
module tb_input_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  btn_raw;
  logic [11:0] wheel_raw;
  logic [7:0]  btn_level, btn_press, btn_release, btn_repeat;
  logic [11:0] wheel_pos;
  logic        wheel_changed;

  input_conditioner #(
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (10),
    .REPEAT_RATE_CYC  (3),
    .REPEAT_MASK      (8'hF0),
    .WHEEL_HYST       (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .wheel_raw     (wheel_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_repeat    (btn_repeat),
    .wheel_pos     (wheel_pos),
    .wheel_changed (wheel_changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [7:0]  lvl, prs, rel, rpt;
    logic        chg;
    logic [11:0] pos;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic void exp_ev(int at, logic [7:0] lvl, logic [7:0] prs, logic [7:0] rel,
                                 logic [7:0] rpt, logic chg, logic [11:0] pos);
    ev_t e;
    e.at = at; e.lvl = lvl; e.prs = prs; e.rel = rel; e.rpt = rpt; e.chg = chg; e.pos = pos;
    sb.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    ev_t e;
    if ((|btn_press) || (|btn_release) || (|btn_repeat) || wheel_changed) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event cyc=%0d lvl=%h prs=%h rel=%h rpt=%h chg=%b pos=%h",
                 cyc, btn_level, btn_press, btn_release, btn_repeat, wheel_changed, wheel_pos);
      end else begin
        e = sb.pop_front();
        if (e.at != cyc || e.lvl !== btn_level || e.prs !== btn_press || e.rel !== btn_release ||
            e.rpt !== btn_repeat || e.chg !== wheel_changed || e.pos !== wheel_pos) begin
          n_err++;
          $display("FAIL event got cyc=%0d lvl=%h prs=%h rel=%h rpt=%h chg=%b pos=%h exp cyc=%0d lvl=%h prs=%h rel=%h rpt=%h chg=%b pos=%h",
                   cyc, btn_level, btn_press, btn_release, btn_repeat, wheel_changed, wheel_pos,
                   e.at, e.lvl, e.prs, e.rel, e.rpt, e.chg, e.pos);
        end
      end
    end
  end

  task automatic check_zero(string name);
    n_vec++;
    if ({btn_level, btn_press, btn_release, btn_repeat, wheel_pos, wheel_changed} !== '0) begin
      n_err++;
      $display("FAIL %s got lvl=%h prs=%h rel=%h rpt=%h pos=%h chg=%b exp all 0",
               name, btn_level, btn_press, btn_release, btn_repeat, wheel_pos, wheel_changed);
    end
  endtask

  task automatic wheel_step(logic [11:0] v, bit upd);
    wheel_raw = v;
    if (upd) exp_ev(cyc + 4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, v);
    tick(8);
  endtask

  initial begin
    int t;
    int r;
    ev_t e;
    reset     = 1'b1;
    btn_raw   = 8'h00;
    wheel_raw = 12'h400;
    tick(3);
    @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    // first settled reading after reset is taken as-is
    exp_ev(cyc + 4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 12'h400);
    tick(8);

    // hysteresis
    wheel_step(12'h405, 1'b0);
    wheel_step(12'h408, 1'b1);
    wheel_step(12'h400, 1'b1);
    wheel_step(12'h3F9, 1'b0);
    wheel_step(12'h000, 1'b1);
    wheel_step(12'hFFF, 1'b1);
    // never stable while toggling, settles back onto current position
    for (int i = 0; i < 20; i++) begin
      wheel_raw = (i % 2 == 0) ? 12'h000 : 12'hFFF;
      tick(1);
    end
    tick(8);

    // A: unmasked, held past the repeat delay -> single press, no repeats
    btn_raw = 8'h01;
    exp_ev(cyc + 6, 8'h01, 8'h01, 8'h00, 8'h01, 1'b0, 12'hFFF);
    tick(14);
    btn_raw = 8'h00;
    exp_ev(cyc + 6, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 12'hFFF);
    tick(12);

    // B: 3-cycle glitch is filtered
    btn_raw = 8'h02;
    tick(3);
    btn_raw = 8'h00;
    tick(10);

    // B: 4 cycles high is just enough
    btn_raw = 8'h02;
    exp_ev(cyc + 6,  8'h02, 8'h02, 8'h00, 8'h02, 1'b0, 12'hFFF);
    exp_ev(cyc + 10, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 12'hFFF);
    tick(4);
    btn_raw = 8'h00;
    tick(12);

    // Up: auto-repeat, release coincides with a repeat tick
    btn_raw = 8'h40;
    t = cyc + 6;
    exp_ev(t, 8'h40, 8'h40, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 10, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 13, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 16, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 19, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 22, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    tick(25);
    btn_raw = 8'h00;
    exp_ev(t + 25, 8'h00, 8'h00, 8'h40, 8'h00, 1'b0, 12'hFFF);
    tick(20);

    // Start + Up held, reset while Up is repeating
    btn_raw = 8'h48;
    t = cyc;
    exp_ev(t + 6,  8'h48, 8'h48, 8'h00, 8'h48, 1'b0, 12'hFFF);
    exp_ev(t + 16, 8'h48, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    exp_ev(t + 19, 8'h48, 8'h00, 8'h00, 8'h40, 1'b0, 12'hFFF);
    tick(20);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    check_zero("reset_mid_repeat");
    reset   = 1'b0;
    btn_raw = 8'h08;
    r = cyc;
    exp_ev(r + 4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 12'hFFF);
    exp_ev(r + 6, 8'h08, 8'h08, 8'h00, 8'h08, 1'b0, 12'hFFF);
    tick(14);
    btn_raw = 8'h00;
    exp_ev(cyc + 6, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0, 12'hFFF);
    tick(12);

    tick(10);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_event exp cyc=%0d lvl=%h prs=%h rel=%h rpt=%h chg=%b pos=%h",
               e.at, e.lvl, e.prs, e.rel, e.rpt, e.chg, e.pos);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
